alu_result_collector: RTL and testbench

- Downstream stage of the ALU function decoder. Consumes the one-hot unit enables (Arith/Logic/CMP/Shift) and the registered outputs of the four execution units.
- Selects the result of the unit that was enabled and tags it with its source unit.
- Buffers results in a small FIFO and presents them to the system side (register file / UART TX framer) over a valid/ready handshake.

---
 rtl/alu_result_collector_if.sv | 27 ++
 rtl/alu_result_collector.sv | 133 +++++++++++++
 tb/tb_alu_result_collector.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_collector_if.sv
// Result-side bundle of the ALU result collector: head entry of the result
// FIFO offered to the register file / UART TX framer under valid/ready.
interface alu_result_collector_if #(
  parameter int OUT_WIDTH = 16
);
  logic                 RES_VALID;
  logic                 RES_READY;
  logic [OUT_WIDTH-1:0] RES_DATA;
  logic                 RES_CARRY;
  logic [1:0]           RES_SRC;

  modport master (
    output RES_VALID,
    output RES_DATA,
    output RES_CARRY,
    output RES_SRC,
    input  RES_READY
  );

  modport slave (
    input  RES_VALID,
    input  RES_DATA,
    input  RES_CARRY,
    input  RES_SRC,
    output RES_READY
  );
endinterface

// File: rtl/alu_result_collector.sv
// Collects the result of whichever ALU unit the decoder enabled, tags it with
// its source unit and queues it in a small FIFO for the system-side consumer.
module alu_result_collector #(
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ALU_EN,
  input  logic                 Arith_enable,
  input  logic                 Logic_enable,
  input  logic                 CMP_enable,
  input  logic                 Shift_enable,
  input  logic [OUT_WIDTH-1:0] Arith_OUT,
  input  logic                 Carry_OUT,
  input  logic [OUT_WIDTH-1:0] Logic_OUT,
  input  logic [OUT_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_WIDTH-1:0] Shift_OUT,
  alu_result_collector_if.master res,
  output logic [CNT_W-1:0]     FIFO_COUNT,
  output logic                 FIFO_FULL,
  output logic                 OVF_ERR,
  output logic                 ILL_ERR
);

  localparam int PTR_W = $clog2(DEPTH);

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] encode_src(input logic [3:0] v);
    logic [1:0] s;
    s = 2'b00;
    if (v[1]) s = 2'b01;
    if (v[2]) s = 2'b10;
    if (v[3]) s = 2'b11;
    return s;
  endfunction

  logic [3:0]           ens_p0;
  logic                 ens_ok_p0;
  logic                 vld_p1;
  logic [1:0]           src_p1;
  logic [OUT_WIDTH-1:0] wr_data_p1;
  logic                 wr_carry_p1;

  logic [OUT_WIDTH-1:0] mem_data  [DEPTH];
  logic                 mem_carry [DEPTH];
  logic [1:0]           mem_src   [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // ---- stage 0 -> 1: capture the decoder enables ----
  assign ens_p0    = {Shift_enable, CMP_enable, Logic_enable, Arith_enable};
  assign ens_ok_p0 = is_onehot(ens_p0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1  <= 1'b0;
      src_p1  <= 2'b00;
      ILL_ERR <= 1'b0;
    end else begin
      vld_p1 <= ALU_EN & ens_ok_p0;
      src_p1 <= encode_src(ens_p0);
      if (ALU_EN && !ens_ok_p0)
        ILL_ERR <= 1'b1;
    end
  end

  // ---- stage 1 -> 2: select the unit output that is now valid, write FIFO ----
  always_comb begin
    wr_data_p1  = Arith_OUT;
    wr_carry_p1 = 1'b0;
    case (src_p1)
      2'b00: begin
        wr_data_p1  = Arith_OUT;
        wr_carry_p1 = Carry_OUT;
      end
      2'b01:   wr_data_p1 = Logic_OUT;
      2'b10:   wr_data_p1 = CMP_OUT;
      default: wr_data_p1 = Shift_OUT;
    endcase
  end

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign pop  = res.RES_VALID & res.RES_READY;
  assign push = vld_p1 & (~FIFO_FULL | pop);
  assign drop = vld_p1 & FIFO_FULL & ~pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_carry[i] <= 1'b0;
        mem_src[i]   <= 2'b00;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      OVF_ERR <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wr_ptr]  <= wr_data_p1;
        mem_carry[wr_ptr] <= wr_carry_p1;
        mem_src[wr_ptr]   <= src_p1;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)
        OVF_ERR <= 1'b1;
    end
  end

  assign FIFO_COUNT    = count;
  assign FIFO_FULL     = (count == CNT_W'(DEPTH));
  assign res.RES_VALID = (count != '0);
  assign res.RES_DATA  = mem_data[rd_ptr];
  assign res.RES_CARRY = mem_carry[rd_ptr];
  assign res.RES_SRC   = mem_src[rd_ptr];

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: expected entries are queued as
// operations are issued and checked as the FIFO head is consumed.
module tb_alu_result_collector;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ALU_EN, Arith_enable, Logic_enable, CMP_enable, Shift_enable;
  logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
  logic        Carry_OUT;
  logic [2:0]  FIFO_COUNT;
  logic        FIFO_FULL, OVF_ERR, ILL_ERR;

  alu_result_collector_if #(.OUT_WIDTH(16)) rif ();

  alu_result_collector #(.OUT_WIDTH(16), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .ALU_EN(ALU_EN),
    .Arith_enable(Arith_enable), .Logic_enable(Logic_enable),
    .CMP_enable(CMP_enable), .Shift_enable(Shift_enable),
    .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .res(rif),
    .FIFO_COUNT(FIFO_COUNT), .FIFO_FULL(FIFO_FULL),
    .OVF_ERR(OVF_ERR), .ILL_ERR(ILL_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] d;
    logic        c;
    logic [1:0]  s;
  } item_t;

  item_t       sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  pend_s = 2'b00;
  logic [15:0] pend_d = 16'h0000;
  logic        pend_c = 1'b0;

  function automatic logic [1:0] src_of(input logic [3:0] ens);
    case (ens)
      4'b0010: return 2'b01;
      4'b0100: return 2'b10;
      4'b1000: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // One clock cycle: consume/check the head, present the unit outputs of the
  // op captured on the previous edge, then drive this cycle's op and ready.
  task automatic cyc(input bit alu_en, input logic [3:0] ens, input logic [15:0] d,
                     input bit c, input bit rdy, input bit exp_push);
    item_t it;
    item_t got;
    @(negedge CLK);
    if (rif.RES_VALID && rdy) begin
      n_cmp++;
      got = {rif.RES_DATA, rif.RES_CARRY, rif.RES_SRC};
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: popped data=%h carry=%b src=%b, no entry expected",
                 got.d, got.c, got.s);
      end else begin
        it = sb.pop_front();
        if (got !== it) begin
          n_bad++;
          $display("FAIL sb_head: got data=%h carry=%b src=%b, want data=%h carry=%b src=%b",
                   got.d, got.c, got.s, it.d, it.c, it.s);
        end
      end
    end
    n_cmp++;
    if (FIFO_COUNT > 3'd4) begin
      n_bad++;
      $display("FAIL count_bound: FIFO_COUNT=%0d, must not exceed 4", FIFO_COUNT);
    end
    Arith_OUT = (pend_s == 2'b00) ? pend_d : 16'hA1A1;
    Logic_OUT = (pend_s == 2'b01) ? pend_d : 16'hB2B2;
    CMP_OUT   = (pend_s == 2'b10) ? pend_d : 16'hC3C3;
    Shift_OUT = (pend_s == 2'b11) ? pend_d : 16'hD4D4;
    Carry_OUT = (pend_s == 2'b00) ? pend_c : 1'b1;
    ALU_EN = alu_en;
    {Shift_enable, CMP_enable, Logic_enable, Arith_enable} = ens;
    rif.RES_READY = rdy;
    pend_s = src_of(ens);
    pend_d = d;
    pend_c = c;
    if (exp_push)
      sb.push_back({d, c & (src_of(ens) == 2'b00), src_of(ens)});
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 4'b0000, 16'h0000, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ALU_EN = 1'b0;
    {Shift_enable, CMP_enable, Logic_enable, Arith_enable} = 4'b0000;
    rif.RES_READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    sb.delete();
    RST = 1'b0;
  endtask

  task automatic fill_four();
    cyc(1'b1, 4'b0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'b0010, 16'h0002, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'b0100, 16'h0003, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'b1000, 16'h0004, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain_check(input int n);
    for (int i = 0; i < n; i++) idle(1'b1);
    n_cmp++;
    if (sb.size() !== 0 || FIFO_COUNT !== 3'd0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries never seen, FIFO_COUNT=%0d want 0",
               sb.size(), FIFO_COUNT);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ALU_EN = 1'b0;
    {Shift_enable, CMP_enable, Logic_enable, Arith_enable} = 4'b0000;
    {Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT} = '0;
    Carry_OUT = 1'b0;
    rif.RES_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({rif.RES_VALID, FIFO_COUNT, FIFO_FULL, OVF_ERR, ILL_ERR} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: valid=%b count=%0d full=%b ovf=%b ill=%b, want all 0",
               rif.RES_VALID, FIFO_COUNT, FIFO_FULL, OVF_ERR, ILL_ERR);
    end
    n_cmp++;
    if ({rif.RES_DATA, rif.RES_CARRY, rif.RES_SRC} !== 19'b0) begin
      n_bad++;
      $display("FAIL reset_head: data=%h carry=%b src=%b, want 0", rif.RES_DATA,
               rif.RES_CARRY, rif.RES_SRC);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_single_arith();
    do_reset();
    cyc(1'b1, 4'b0001, 16'h00FF, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    n_cmp++;
    if (rif.RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_early: RES_VALID=%b one cycle after enable, want 0", rif.RES_VALID);
    end
    idle(1'b1);
    n_cmp++;
    if ({rif.RES_VALID, rif.RES_DATA, rif.RES_CARRY, rif.RES_SRC} !== {1'b1, 16'h00FF, 1'b1, 2'b00}) begin
      n_bad++;
      $display("FAIL single_arith: valid=%b data=%h carry=%b src=%b, want 1 00ff 1 00",
               rif.RES_VALID, rif.RES_DATA, rif.RES_CARRY, rif.RES_SRC);
    end
    idle(1'b1);
    n_cmp++;
    if ({rif.RES_VALID, FIFO_COUNT} !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_pop: valid=%b count=%0d, want 0 0", rif.RES_VALID, FIFO_COUNT);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_four();
    idle(1'b0);
    idle(1'b0);
    n_cmp++;
    if ({FIFO_COUNT, FIFO_FULL} !== {3'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_full: count=%0d full=%b, want 4 1", FIFO_COUNT, FIFO_FULL);
    end
    drain_check(5);
  endtask

  task automatic test_overflow();
    do_reset();
    fill_four();
    cyc(1'b1, 4'b0001, 16'hDEAD, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    n_cmp++;
    if ({OVF_ERR, FIFO_COUNT} !== {1'b1, 3'd4}) begin
      n_bad++;
      $display("FAIL ovf_drop: ovf=%b count=%0d, want 1 4", OVF_ERR, FIFO_COUNT);
    end
    drain_check(5);

    do_reset();
    fill_four();
    idle(1'b0);
    cyc(1'b1, 4'b0010, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);
    n_cmp++;
    if ({OVF_ERR, FIFO_COUNT, FIFO_FULL} !== {1'b0, 3'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL full_pop_write: ovf=%b count=%0d full=%b, want 0 4 1",
               OVF_ERR, FIFO_COUNT, FIFO_FULL);
    end
    drain_check(5);
  endtask

  task automatic test_illegal();
    do_reset();
    cyc(1'b1, 4'b0101, 16'h1234, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    n_cmp++;
    if ({ILL_ERR, rif.RES_VALID, FIFO_COUNT} !== {1'b1, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL ill_multi: ill=%b valid=%b count=%0d, want 1 0 0",
               ILL_ERR, rif.RES_VALID, FIFO_COUNT);
    end
    do_reset();
    cyc(1'b1, 4'b0000, 16'h1111, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    n_cmp++;
    if ({ILL_ERR, FIFO_COUNT} !== {1'b1, 3'd0}) begin
      n_bad++;
      $display("FAIL ill_none: ill=%b count=%0d, want 1 0", ILL_ERR, FIFO_COUNT);
    end
    do_reset();
    cyc(1'b0, 4'b1000, 16'h5678, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    n_cmp++;
    if ({ILL_ERR, rif.RES_VALID, FIFO_COUNT} !== {1'b0, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL alu_en_low: ill=%b valid=%b count=%0d, want 0 0 0",
               ILL_ERR, rif.RES_VALID, FIFO_COUNT);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1'b1, 4'b0011, 16'h0BAD, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 16'h0011, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 4'b0010, 16'h0022, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'b0100, 16'h0033, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'b1000, 16'h4444, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    n_cmp++;
    if ({FIFO_COUNT, ILL_ERR} !== {3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset: count=%0d ill=%b, want 3 1", FIFO_COUNT, ILL_ERR);
    end
    #1 RST = 1'b1;
    #1;
    n_cmp++;
    if ({rif.RES_VALID, FIFO_COUNT, OVF_ERR, ILL_ERR} !== 6'b0) begin
      n_bad++;
      $display("FAIL async_reset: valid=%b count=%0d ovf=%b ill=%b, want all 0",
               rif.RES_VALID, FIFO_COUNT, OVF_ERR, ILL_ERR);
    end
    sb.delete();
    @(negedge CLK);
    RST = 1'b0;
    ALU_EN = 1'b0;
    {Shift_enable, CMP_enable, Logic_enable, Arith_enable} = 4'b0000;
    drain_check(4);
  endtask

  task automatic test_wrap_toggle();
    int k;
    logic [3:0] ens;
    do_reset();
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 2) begin
        idle(i % 2 == 0);
      end else begin
        ens = 4'b0001 << (k % 4);
        cyc(1'b1, ens, 16'h0100 + 16'(k), k[0], i % 2 == 0, 1'b1);
        k++;
      end
    end
    drain_check(8);
  endtask

  initial begin
    test_reset();
    test_single_arith();
    test_back_to_back();
    test_overflow();
    test_illegal();
    test_async_reset();
    test_wrap_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
